// File: rtl/dptr_pkg.sv
// dptr_pkg: instruction-field constants, funct codes and the ALU-op enum
// shared by the dptr_pipe register file and pipeline.
package dptr_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int SH_HI = 10;
    localparam int SH_LO = 6;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_ILL
    } alu_op_e;

    function automatic alu_op_e decode_funct(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            FN_SLTU: return ALU_SLTU;
            default: return ALU_ILL;
        endcase
    endfunction

endpackage

// File: rtl/dptr_regfile.sv
// dptr_regfile: NREG x DATA_W register file, two read ports, one pipeline
// write port plus a preload port; writes are visible to same-cycle reads.
module dptr_regfile
    import dptr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              init_we,
    input  logic [REG_AW-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data
);

    localparam logic [REG_AW:0] NREG_W = (REG_AW+1)'(NREG);

    logic [DATA_W-1:0] r_mem [NREG];

    // NOTE: the array is cleared by reset because the architecture defines
    // every register as 0 after reset; index 0 is never written afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (init_we && init_addr == REG_AW'(i))
                    r_mem[i] <= init_data;
                else if (we && waddr == REG_AW'(i))
                    r_mem[i] <= wdata;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (rd_addr_a != '0 && {1'b0, rd_addr_a} < NREG_W)
            rd_data_a = (we && waddr == rd_addr_a) ? wdata : r_mem[rd_addr_a];
        if (rd_addr_b != '0 && {1'b0, rd_addr_b} < NREG_W)
            rd_data_b = (we && waddr == rd_addr_b) ? wdata : r_mem[rd_addr_b];
    end

endmodule

// File: rtl/dptr_pipe.sv
// dptr_pipe: 3-stage (ID/EX/WB) MIPS R-type datapath with register preload.
// Define DPTR_FORWARDING_EN for result bypassing; otherwise hazards interlock.
module dptr_pipe
    import dptr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruccion,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              init_we,
    input  logic [REG_AW-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_result,
    output logic              ZF_DPTR,
    output logic              ovf,
    output logic              illegal
);

    localparam logic [REG_AW:0] NREG_W = (REG_AW+1)'(NREG);

    // ID stage: field extraction, decode, register read
    logic [REG_AW-1:0] w_rs, w_rt, w_rd;
    logic [DATA_W-1:0] w_rf_a, w_rf_b, w_op_a, w_op_b;
    alu_op_e           w_id_op;
    logic              w_id_legal, w_accept;
    logic              w_unused_shamt;

    assign w_rs    = instruccion[RS_HI:RS_LO];
    assign w_rt    = instruccion[RT_HI:RT_LO];
    assign w_rd    = instruccion[RD_HI:RD_LO];
    assign w_id_op = decode_funct(instruccion[FN_HI:FN_LO]);
    assign w_unused_shamt = ^instruccion[SH_HI:SH_LO];

    assign w_id_legal = (instruccion[OP_HI:OP_LO] == OP_RTYPE) && (w_id_op != ALU_ILL)
                     && ({1'b0, w_rs} < NREG_W) && ({1'b0, w_rt} < NREG_W)
                     && ({1'b0, w_rd} < NREG_W);

    // EX stage registers
    logic              r_ex_valid, r_ex_legal;
    alu_op_e           r_ex_op;
    logic [REG_AW-1:0] r_ex_rd;
    logic [DATA_W-1:0] r_ex_a, r_ex_b;

    // WB stage registers
    logic              r_wb_valid, r_wb_illegal, r_zf, r_ovf;
    logic [REG_AW-1:0] r_wb_rd;
    logic [DATA_W-1:0] r_wb_result;

    logic [DATA_W-1:0] w_alu_result, w_sum, w_diff;
    logic              w_alu_ovf;

    dptr_regfile #(.DATA_W(DATA_W), .NREG(NREG), .REG_AW(REG_AW)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (w_rs),
        .rd_addr_b (w_rt),
        .rd_data_a (w_rf_a),
        .rd_data_b (w_rf_b),
        .we        (r_wb_valid && !r_wb_illegal),
        .waddr     (r_wb_rd),
        .wdata     (r_wb_result),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

`ifdef DPTR_FORWARDING_EN
    // Distance 1 takes the live ALU result; distance 2 is covered by the
    // register file's write-through of the WB write.
    logic w_fwd_a, w_fwd_b;
    assign w_fwd_a = r_ex_valid && r_ex_legal && r_ex_rd != '0 && r_ex_rd == w_rs;
    assign w_fwd_b = r_ex_valid && r_ex_legal && r_ex_rd != '0 && r_ex_rd == w_rt;
    assign w_op_a  = w_fwd_a ? w_alu_result : w_rf_a;
    assign w_op_b  = w_fwd_b ? w_alu_result : w_rf_b;
    assign instr_ready = !init_we;
`else
    logic w_ex_hit, w_wb_hit, w_hazard;
    assign w_ex_hit = r_ex_valid && r_ex_legal && r_ex_rd != '0;
    assign w_wb_hit = r_wb_valid && !r_wb_illegal && r_wb_rd != '0;
    assign w_hazard = instr_valid && (
        (w_rs != '0 && ((w_ex_hit && w_rs == r_ex_rd) || (w_wb_hit && w_rs == r_wb_rd))) ||
        (w_rt != '0 && ((w_ex_hit && w_rt == r_ex_rd) || (w_wb_hit && w_rt == r_wb_rd))));
    assign w_op_a  = w_rf_a;
    assign w_op_b  = w_rf_b;
    assign instr_ready = !init_we && !w_hazard;
`endif

    assign w_accept = instr_valid && instr_ready;

    // NOTE: sequential state uses non-blocking assignments so all stages
    // sample the previous-cycle values of each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_legal <= 1'b0;
            r_ex_op    <= ALU_ADD;
            r_ex_rd    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
        end else begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_ex_legal <= w_id_legal;
                r_ex_op    <= w_id_op;
                r_ex_rd    <= w_rd;
                r_ex_a     <= w_op_a;
                r_ex_b     <= w_op_b;
            end
        end
    end

    assign w_sum  = r_ex_a + r_ex_b;
    assign w_diff = r_ex_a - r_ex_b;

    always_comb begin
        w_alu_result = '0;
        w_alu_ovf    = 1'b0;
        case (r_ex_op)
            ALU_ADD: begin
                w_alu_result = w_sum;
                w_alu_ovf    = (r_ex_a[DATA_W-1] == r_ex_b[DATA_W-1])
                            && (w_sum[DATA_W-1] != r_ex_a[DATA_W-1]);
            end
            ALU_SUB: begin
                w_alu_result = w_diff;
                w_alu_ovf    = (r_ex_a[DATA_W-1] != r_ex_b[DATA_W-1])
                            && (w_diff[DATA_W-1] != r_ex_a[DATA_W-1]);
            end
            ALU_AND:  w_alu_result = r_ex_a & r_ex_b;
            ALU_OR:   w_alu_result = r_ex_a | r_ex_b;
            ALU_NOR:  w_alu_result = ~(r_ex_a | r_ex_b);
            ALU_SLT:  w_alu_result = {{(DATA_W-1){1'b0}}, $signed(r_ex_a) < $signed(r_ex_b)};
            ALU_SLTU: w_alu_result = {{(DATA_W-1){1'b0}}, r_ex_a < r_ex_b};
            default:  w_alu_result = '0;
        endcase
    end

    // Flags only move on legal retirements; illegal ones report a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid   <= 1'b0;
            r_wb_illegal <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_result  <= '0;
            r_zf         <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_wb_valid   <= r_ex_valid;
            r_wb_illegal <= r_ex_valid && !r_ex_legal;
            if (r_ex_valid) begin
                r_wb_rd     <= r_ex_rd;
                r_wb_result <= r_ex_legal ? w_alu_result : '0;
            end
            if (r_ex_valid && r_ex_legal) begin
                r_zf  <= (w_alu_result == '0);
                r_ovf <= w_alu_ovf;
            end
        end
    end

    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_result = r_wb_result;
    assign ZF_DPTR   = r_zf;
    assign ovf       = r_ovf;
    assign illegal   = r_wb_valid && r_wb_illegal;

endmodule

// File: doc/dptr_pipe.md
Name: dptr_pipe

Overview:
- Clocked, parametrised successor to the combinational R-type datapath (DPTR).
- Accepts one MIPS R-type instruction per cycle. Runs it through a 3-stage pipeline: ID (decode and register read), EX (ALU), WB (register-file write).
- Reports the result, zero flag and overflow flag per retired instruction.
- Includes a preload port so benches and the later single-cycle CPU integration can seed the register file.

Parameters:
- DATA_W, 32, datapath and register width (8..64).
- NREG, 32, number of registers implemented (2..32). Addresses >= NREG are illegal.
- REG_AW, 5, register address width. Fixed by the 32-bit instruction format; must satisfy 2^REG_AW >= NREG.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instruccion  in  32  R-type word: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- instr_valid  in  1  instruccion is valid this cycle.
- instr_ready  out  1  block accepts instruccion this cycle.
- init_we  in  1  register-file preload write strobe.
- init_addr  in  REG_AW  preload address.
- init_data  in  DATA_W  preload data.
- wb_valid  out  1  one-cycle pulse: an instruction retired.
- wb_rd  out  REG_AW  destination of the retired instruction.
- wb_result  out  DATA_W  ALU result of the retired instruction.
- ZF_DPTR  out  1  zero flag, held until the next legal retirement.
- ovf  out  1  signed overflow of the last retired add/sub; 0 for other ops.
- illegal  out  1  one-cycle pulse together with wb_valid when the retired instruction was illegal.

Behaviour:
- Reset (async, rst_n low):
  - All registers = 0; pipeline valid bits = 0.
  - wb_valid, wb_rd, wb_result, ZF_DPTR, ovf, illegal = 0.
  - instr_ready = 1 after release.
- Acceptance: an instruction is accepted when instr_valid && instr_ready at a rising edge.
  - Accepted in cycle N: EX in N+1, outputs valid in N+2, register file written at the end of N+2.
  - Latency is 2 cycles.
- instr_ready = 0 while init_we = 1. Preload has priority and writes at the clock edge.
- init_we to register 0 is ignored.
- ALU functions (by funct), computed modulo 2^DATA_W:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor.
  - 0x2A slt: signed compare, result 1 or 0.
  - 0x2B sltu: unsigned compare, result 1 or 0.
- shamt is ignored.
- Illegal when op != 0, funct is unlisted, or rs/rt/rd >= NREG. An illegal instruction:
  - flows through the pipeline and pulses wb_valid and illegal;
  - writes nothing and leaves ZF_DPTR and ovf unchanged;
  - drives wb_result = 0.
- Register 0 reads 0 always. A write to rd = 0 is discarded, but wb_valid still pulses and ZF_DPTR is still updated.
- ZF_DPTR = (result == 0) of the last legal retirement.
- ovf: for add, operand signs equal and result sign differs. For sub, operand signs differ and result sign differs from rs. No trap.
- Same-cycle hazards: a WB write and an ID read of the same register return the new value (write-through bypass inside the register file).
- Reset mid-operation: in-flight instructions are discarded and no wb_valid is produced for them.

Optional Feature:
- DPTR_FORWARDING_EN defined:
  - EX-to-EX bypass (distance 1) and WB-to-EX bypass (distance 2).
  - instr_ready depends only on init_we; back-to-back dependent instructions issue every cycle.
- DPTR_FORWARDING_EN undefined:
  - Interlock. instr_ready = 0 while instruccion is valid and its rs or rt (non-zero) matches the rd of a valid, legal instruction in EX or WB.
  - Worst-case dependent issue interval is 3 cycles.
- Architectural results are identical with and without the macro.

Decomposition:
- Package dptr_pkg holds:
  - funct localparams (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU);
  - OP_RTYPE;
  - the instruction-field bit-slice constants;
  - the ALU-op enum.
- Sub-module dptr_regfile: NREG x DATA_W, 2 read ports, 1 write port plus the preload port, write-through, register 0 fixed at zero.
- The ALU stays inline in the EX stage.

Test Plan:
- Preload $15=5, $9=3; issue sub $20,$15,$9 (0x01E9A022) -> at N+2: wb_valid=1, wb_rd=20, wb_result=2, ZF_DPTR=0.
- Back-to-back, with $20=2 from the previous scenario: sub $21,$20,$9 then add $22,$5,$15 with $5=0:
  - wb_result -1 (0xFFFFFFFF), then 5.
  - With the macro: no stall.
  - Without the macro: instr_ready low for 2 cycles on the dependent instruction.
- Preload $20=7, $15=7; issue slt $24,$20,$15 (0x028FC02A) -> wb_result=0, ZF_DPTR=1. Then slt with $20=-1 -> wb_result=1, ZF_DPTR=0.
- Preload $1=0x7FFFFFFF, $2=1; issue add $3,$1,$2 -> wb_result=0x80000000, ovf=1. Then sub $3,$1,$1 -> 0, ovf=0, ZF_DPTR=1.
- Issue op=0x08 word, then funct=0x3F word -> each gives wb_valid=1 and illegal=1; ZF_DPTR unchanged; no register written.
- Assert rst_n low with 2 instructions in flight -> no wb_valid afterwards; all outputs 0; register file reads 0.
